// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/client types and memory width macros for the memory port arbiter.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST} ARB_STATE_T;
  typedef enum logic [1:0] {CL_IF, CL_WT, CL_CP} ARB_CLIENT_T;
  function automatic ARB_CLIENT_T onehot_client(input logic [2:0] oh);
    return oh[2] ? CL_CP : oh[1] ? CL_WT : CL_IF;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: one-hot requester select over {if, wt, cp}; MEM_ARB_ROUND_ROBIN_EN selects
// round-robin after the last grant, otherwise fixed priority cp > wt > if.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  req,
  input  ARB_CLIENT_T last,
  output logic [2:0]  pick,
  output logic        valid
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] sh;
  logic [2:0] rot;
  logic [2:0] oh;
  always_comb begin
    sh = (last == CL_CP) ? 2'd0 : 2'(last) + 2'd1;
    rot = 3'({req, req} >> sh);
    oh = rot & (~rot + 3'd1);
    pick = 3'(({oh, oh} << sh) >> 3);
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  assign pick = req[2] ? 3'b100 : req[1] ? 3'b010 : {2'b00, req[0]};
`endif
  assign valid = |req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter for ifmap/weight read bursts and compressor write bursts.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = `MEM_ADDR_SIZE,
  parameter int DATA_W = `MEM_BANDWIDTH*8,
  parameter int LEN_W  = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_done,
  input  logic              wt_req,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic [LEN_W-1:0]  wt_len,
  output logic              wt_gnt,
  output logic              wt_rvalid,
  output logic              wt_done,
  input  logic              cp_req,
  input  logic [ADDR_W-1:0] cp_addr,
  input  logic [LEN_W-1:0]  cp_len,
  output logic              cp_gnt,
  input  logic [DATA_W-1:0] cp_wdata,
  input  logic              cp_wvalid,
  output logic              cp_wready,
  output logic              cp_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_valid,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [LEN_W-1:0]  L_ONE = 1;
  ARB_STATE_T        state, state_n;
  ARB_CLIENT_T       owner, owner_n, last, last_n;
  logic [ADDR_W-1:0] cur_addr, addr_n, sel_addr;
  logic [LEN_W-1:0]  remain, remain_n, sel_len;
  logic [2:0]        gnt_q, gnt_n, done_q, done_n, pick;
  logic [1:0]        rvalid_q, rvalid_n;
  logic [DATA_W-1:0] rd_q, rd_n;
  logic              mem_read_q, busy_q, pick_valid;
  arb_pick u_pick (
    .req   ({cp_req, wt_req, if_req}),
    .last  (last),
    .pick  (pick),
    .valid (pick_valid)
  );
  assign sel_addr = pick[2] ? cp_addr : pick[1] ? wt_addr : if_addr;
  assign sel_len  = pick[2] ? cp_len : pick[1] ? wt_len : if_len;
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    last_n   = last;
    addr_n   = cur_addr;
    remain_n = remain;
    gnt_n    = gnt_q;
    done_n   = '0;
    rvalid_n = '0;
    rd_n     = rd_q;
    case (state)
      IDLE: if (pick_valid) begin
        last_n = onehot_client(pick);
        if (sel_len == '0) done_n = pick;
        else begin
          gnt_n    = pick;
          owner_n  = onehot_client(pick);
          addr_n   = sel_addr;
          remain_n = sel_len;
          state_n  = pick[2] ? WR_BURST : RD_ISSUE;
        end
      end
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT: if (mem_valid) begin
        rd_n     = mem_read_data;
        rvalid_n = (owner == CL_WT) ? 2'b10 : 2'b01;
        addr_n   = cur_addr + A_ONE;
        remain_n = remain - L_ONE;
        state_n  = (remain == L_ONE) ? IDLE : RD_ISSUE;
        done_n   = (remain == L_ONE) ? gnt_q : 3'b000;
        gnt_n    = (remain == L_ONE) ? 3'b000 : gnt_q;
      end
      WR_BURST: if (cp_wvalid) begin
        addr_n   = cur_addr + A_ONE;
        remain_n = remain - L_ONE;
        state_n  = (remain == L_ONE) ? IDLE : WR_BURST;
        done_n   = (remain == L_ONE) ? 3'b100 : 3'b000;
        gnt_n    = (remain == L_ONE) ? 3'b000 : gnt_q;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= CL_IF;
      last       <= CL_IF;
      cur_addr   <= '0;
      remain     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rvalid_q   <= '0;
      rd_q       <= '0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last       <= last_n;
      cur_addr   <= addr_n;
      remain     <= remain_n;
      gnt_q      <= gnt_n;
      done_q     <= done_n;
      rvalid_q   <= rvalid_n;
      rd_q       <= rd_n;
      mem_read_q <= (state_n == RD_ISSUE);
      busy_q     <= (state_n != IDLE);
    end
  end
  // write beats go straight through so the compressor sustains one beat per cycle
  assign cp_wready      = (state == WR_BURST);
  assign mem_write      = cp_wready && cp_wvalid;
  assign mem_write_data = mem_write ? cp_wdata : '0;
  assign mem_read       = mem_read_q;
  assign mem_addr       = (mem_read_q || mem_write) ? cur_addr : '0;
  assign {cp_gnt, wt_gnt, if_gnt}    = gnt_q;
  assign {cp_done, wt_done, if_done} = done_q;
  assign {wt_rvalid, if_rvalid}      = rvalid_q;
  assign rd_data = rd_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int AW = `MEM_ADDR_SIZE;
  localparam int DW = `MEM_BANDWIDTH*8;
  localparam int LW = 16;
  typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} acc_t;
  typedef struct {logic wt; logic [DW-1:0] data;} beat_t;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, wt_req = 0, cp_req = 0, cp_wvalid = 0;
  logic [AW-1:0] if_addr = '0, wt_addr = '0, cp_addr = '0;
  logic [LW-1:0] if_len = '0, wt_len = '0, cp_len = '0;
  logic [DW-1:0] cp_wdata = '0, mem_read_data = '0;
  logic mem_valid = 0;
  logic if_gnt, wt_gnt, cp_gnt, if_rvalid, wt_rvalid, if_done, wt_done, cp_done, cp_wready;
  logic mem_read, mem_write, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data, rd_data;
  logic [11+AW+2*DW:0] outs;
  int total = 0, bad = 0;
  acc_t exp_mem[$];
  beat_t exp_rd[$];
  ARB_CLIENT_T gnt_log[$];
  logic mem_en = 0, stale = 0, mp = 0;
  logic [AW-1:0] ma = '0;
  logic [2:0] gnt_prev = '0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_done(if_done),
    .wt_req(wt_req), .wt_addr(wt_addr), .wt_len(wt_len), .wt_gnt(wt_gnt), .wt_rvalid(wt_rvalid), .wt_done(wt_done),
    .cp_req(cp_req), .cp_addr(cp_addr), .cp_len(cp_len), .cp_gnt(cp_gnt), .cp_wdata(cp_wdata),
    .cp_wvalid(cp_wvalid), .cp_wready(cp_wready), .cp_done(cp_done),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_read_data(mem_read_data), .mem_valid(mem_valid), .busy(busy)
  );

  assign outs = {if_gnt, wt_gnt, cp_gnt, if_rvalid, wt_rvalid, if_done, wt_done, cp_done,
                 cp_wready, busy, mem_read, mem_write, mem_addr, mem_write_data, rd_data};

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(32'hA5C3_0000);
  endfunction

  // memory answers a read seen in one cycle with mem_valid in the next; stale forces a spurious response
  always begin
    @(negedge clk);
    mp = mem_en && mem_read;
    ma = mem_addr;
    @(posedge clk);
    #1;
    mem_valid = mp || stale;
    mem_read_data = mp ? dat(ma) : DW'(32'hDEAD_BEEF);
  end

  always @(negedge clk) begin
    acc_t e;
    beat_t b;
    if (mem_read || mem_write) begin
      total++;
      if (mem_read && mem_write) begin
        bad++;
        $display("FAIL rw_exclusive: read=%b write=%b, required not both", mem_read, mem_write);
      end
      total++;
      if (exp_mem.size() == 0) begin
        bad++;
        $display("FAIL mem_access: unexpected wr=%b addr=%h, required none", mem_write, mem_addr);
      end else begin
        e = exp_mem.pop_front();
        if ({mem_write, mem_addr, mem_write ? mem_write_data : DW'(0)} !== {e.wr, e.addr, e.data}) begin
          bad++;
          $display("FAIL mem_access: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                   mem_write, mem_addr, mem_write_data, e.wr, e.addr, e.data);
        end
      end
    end
    if (if_rvalid || wt_rvalid) begin
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL rd_beat: unexpected if=%b wt=%b data=%h, required none", if_rvalid, wt_rvalid, rd_data);
      end else begin
        b = exp_rd.pop_front();
        if ({wt_rvalid, if_rvalid, rd_data} !== {b.wt, ~b.wt, b.data}) begin
          bad++;
          $display("FAIL rd_beat: got wt=%b if=%b data=%h, required wt=%b if=%b data=%h",
                   wt_rvalid, if_rvalid, rd_data, b.wt, ~b.wt, b.data);
        end
      end
    end
    if ({cp_gnt, wt_gnt, if_gnt} != 3'b000 && {cp_gnt, wt_gnt, if_gnt} != gnt_prev)
      gnt_log.push_back(cp_gnt ? CL_CP : wt_gnt ? CL_WT : CL_IF);
    gnt_prev = {cp_gnt, wt_gnt, if_gnt};
  end

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (outs !== '0 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL reset_outputs: got %h state %0d, required 0 state 0", outs, dut.state);
    end
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_arbitration;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ARB_CLIENT_T ord[3] = '{CL_WT, CL_CP, CL_IF};
`else
    ARB_CLIENT_T ord[3] = '{CL_CP, CL_WT, CL_IF};
`endif
    logic [AW-1:0] base;
    int ndone = 0;
    if_addr = AW'(32'h300); wt_addr = AW'(32'h400); cp_addr = AW'(32'h500);
    if_len = 2; wt_len = 2; cp_len = 2;
    cp_wvalid = 1; cp_wdata = DW'(32'hC0DE_0001);
    gnt_log.delete();
    foreach (ord[i]) begin
      base = (ord[i] == CL_IF) ? if_addr : (ord[i] == CL_WT) ? wt_addr : cp_addr;
      for (int k = 0; k < 2; k++) begin
        if (ord[i] == CL_CP) exp_mem.push_back('{1'b1, base + AW'(k), cp_wdata});
        else begin
          exp_mem.push_back('{1'b0, base + AW'(k), '0});
          exp_rd.push_back('{ord[i] == CL_WT, dat(base + AW'(k))});
        end
      end
    end
    mem_en = 1;
    @(posedge clk);
    #1 {if_req, wt_req, cp_req} = 3'b111;
    for (int c = 0; c < 80 && ndone < 3; c++) begin
      @(posedge clk);
      #1;
      if (if_gnt) if_req = 0;
      if (wt_gnt) wt_req = 0;
      if (cp_gnt) cp_req = 0;
      @(negedge clk);
      ndone += int'(if_done) + int'(wt_done) + int'(cp_done);
    end
    cp_wvalid = 0;
    {if_req, wt_req, cp_req} = 3'b000;
    total++;
    if (ndone != 3) begin bad++; $display("FAIL arb_done_count: got %0d, required 3", ndone); end
    total++;
    if (gnt_log.size() != 3) begin bad++; $display("FAIL arb_grant_count: got %0d, required 3", gnt_log.size()); end
    else foreach (ord[i]) begin
      total++;
      if (gnt_log[i] !== ord[i]) begin
        bad++;
        $display("FAIL arb_order[%0d]: got %0d, required %0d", i, gnt_log[i], ord[i]);
      end
    end
  endtask

  task automatic test_read_burst;
    int rv = 0, donec = -1;
    if_addr = AW'(32'h100); if_len = 4;
    for (int k = 0; k < 4; k++) begin
      exp_mem.push_back('{1'b0, if_addr + AW'(k), '0});
      exp_rd.push_back('{1'b0, dat(if_addr + AW'(k))});
    end
    @(posedge clk);
    #1 if_req = 1;
    @(posedge clk);
    #1 if_req = 0;
    total++;
    if ({if_gnt, busy} !== 2'b11) begin bad++; $display("FAIL rd_grant_latency: got gnt=%b busy=%b, required 1 1", if_gnt, busy); end
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || mem_addr !== AW'(32'h100)) begin
      bad++;
      $display("FAIL rd_first_issue: got read=%b addr=%h, required 1 100", mem_read, mem_addr);
    end
    for (int c = 0; c < 40 && donec < 0; c++) begin
      @(negedge clk);
      rv += int'(if_rvalid);
      if (if_done) begin
        donec = c;
        total++;
        if (if_rvalid !== 1'b1) begin bad++; $display("FAIL rd_done_with_beat: got rvalid=%b, required 1", if_rvalid); end
      end
    end
    total++;
    if (rv != 4 || donec < 0) begin bad++; $display("FAIL rd_beats: got %0d done_at=%0d, required 4 beats with done", rv, donec); end
    @(negedge clk);
    total++;
    if ({busy, if_gnt} !== 2'b00) begin bad++; $display("FAIL rd_idle_after: got busy=%b gnt=%b, required 0 0", busy, if_gnt); end
  endtask

  task automatic test_write(input logic [AW-1:0] base, input logic [7:0] pat, input int plen, input int span);
    logic [DW-1:0] d[3];
    int idx = 0, wr = 0, first = -1, lastw = -1, donec = -1;
    d = '{DW'(32'hAAAA_0001), DW'(32'hBBBB_0002), DW'(32'hCCCC_0003)};
    for (int k = 0; k < 3; k++) exp_mem.push_back('{1'b1, base + AW'(k), d[k]});
    cp_addr = base; cp_len = 3; cp_wvalid = 0;
    @(posedge clk);
    #1 cp_req = 1;
    for (int c = 0; c < 40 && donec < 0; c++) begin
      @(posedge clk);
      #1 cp_req = 0;
      cp_wvalid = cp_wready && idx < 3 && pat[c % plen];
      cp_wdata = d[idx < 3 ? idx : 0];
      if (cp_wvalid) idx++;
      @(negedge clk);
      if (mem_write) begin
        wr++;
        if (first < 0) first = c;
        lastw = c;
      end
      if (cp_done) donec = c;
    end
    cp_wvalid = 0;
    total++;
    if (wr != 3) begin bad++; $display("FAIL wr_count base %h: got %0d, required 3", base, wr); end
    total++;
    if (donec != lastw + 1) begin bad++; $display("FAIL wr_done base %h: got cycle %0d, required %0d", base, donec, lastw + 1); end
    total++;
    if (lastw - first != span) begin bad++; $display("FAIL wr_span base %h: got %0d, required %0d", base, lastw - first, span); end
  endtask

  task automatic test_zero_len;
    wt_addr = AW'(32'h700); wt_len = 0;
    @(posedge clk);
    #1 wt_req = 1;
    @(posedge clk);
    #1 wt_req = 0;
    @(negedge clk);
    total++;
    if ({wt_done, busy, mem_read, wt_gnt} !== 4'b1000) begin
      bad++;
      $display("FAIL zero_len_done: got done,busy,read,gnt=%b, required 1000", {wt_done, busy, mem_read, wt_gnt});
    end
    @(negedge clk);
    total++;
    if ({wt_done, busy, mem_read} !== 3'b000) begin
      bad++;
      $display("FAIL zero_len_after: got done,busy,read=%b, required 000", {wt_done, busy, mem_read});
    end
  endtask

  task automatic test_reset_mid;
    mem_en = 0;
    if_addr = AW'(32'h600); if_len = 2;
    exp_mem.push_back('{1'b0, if_addr, '0});
    @(posedge clk);
    #1 if_req = 1;
    @(posedge clk);
    #1 if_req = 0;
    @(posedge clk);
    #1;
    total++;
    if (dut.state !== RD_WAIT) begin bad++; $display("FAIL mid_reach_wait: got %0d, required %0d", dut.state, RD_WAIT); end
    rst_n = 0; stale = 1;
    #2;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL mid_async_reset: got %h, required 0", outs); end
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (outs !== '0 || dut.state !== IDLE) begin
        bad++;
        $display("FAIL mid_stale_valid[%0d]: got %h state %0d, required 0 state 0", c, outs, dut.state);
      end
    end
    stale = 0;
    mem_en = 1;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_read_burst();
    test_write(AW'(32'h200), 8'hFF, 1, 2);
    test_write(AW'(32'h210), 8'h15, 5, 4);
    test_zero_len();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got mem=%0d rd=%0d left, required 0 0", exp_mem.size(), exp_rd.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
